// File: rtl/preset_loader_pkg.sv
// Shared constants for the preset loader: FSM encoding, BCD range limits and the clamp value.
package preset_loader_pkg;

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_CAPTURE      = 2'd1;
  localparam logic [1:0] ST_LOAD         = 2'd2;
  localparam logic [1:0] ST_WAIT_RELEASE = 2'd3;

  localparam logic [1:0] BCD_MAX_TENS  = 2'd3;
  localparam logic [3:0] BCD_MAX_UNITS = 4'd9;
  localparam logic [5:0] CLAMP_VALUE   = 6'b11_0000;

  // Counter range is 00..30 BCD, so a tens digit of 3 only allows units 0.
  function automatic logic preset_is_valid(input logic [5:0] p);
    logic [1:0] tens;
    logic [3:0] units;
    tens  = p[5:4];
    units = p[3:0];
    return (units <= BCD_MAX_UNITS) && ((tens < BCD_MAX_TENS) || (units == 4'd0));
  endfunction

endpackage

// File: rtl/preset_loader_if.sv
// Board-side and counter-side signals of the preset loader, plus the FSM debug view.
interface preset_loader_if;
  // set_bits/clear_bits form a qualified strobe with no backpressure: they are nonzero only
  // during the load window, never overlap bitwise, and the counter must accept them as driven.
  logic [5:0] preset;
  logic       button;
  logic [5:0] set_bits;
  logic [5:0] clear_bits;
  logic       busy;
  logic       invalid;
  logic [1:0] fsm_state;

  modport master (output preset, button,
                  input  set_bits, clear_bits, busy, invalid, fsm_state);
  modport slave  (input  preset, button,
                  output set_bits, clear_bits, busy, invalid, fsm_state);
endinterface

// File: rtl/preset_loader_debouncer.sv
// Two-flop synchroniser and stability-counter debouncer with a registered rising-edge pulse.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      rise    <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      rise    <= level & ~level_d;
      // Any sample that agrees with the current level restarts the stability window.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/preset_loader.sv
// Preset loader: debounced load button -> validated per-bit set/clear strobes for the BCD counter.
// Build option PRESET_CLAMP_EN: out-of-range presets load 30 instead of being dropped.
module preset_loader
  import preset_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LOAD_CYCLES     = 2
) (
  input  logic           clock,
  input  logic           reset,
  preset_loader_if.slave bus
);

  localparam int            LW        = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
  localparam logic [LW-1:0] LOAD_LAST = LW'(LOAD_CYCLES - 1);

  logic          level;
  logic          press;
  logic          preset_ok;
  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [5:0]    hold;
  logic [5:0]    hold_nx;
  logic [LW-1:0] lcnt;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
    .clock (clock),
    .reset (reset),
    .raw   (bus.button),
    .level (level),
    .rise  (press)
  );

  assign preset_ok = preset_is_valid(bus.preset);

  always_comb begin
    state_nx = state;
    hold_nx  = hold;
    case (state)
      ST_IDLE: begin
        if (press) state_nx = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        hold_nx = bus.preset;
        if (preset_ok) begin
          state_nx = ST_LOAD;
        end else begin
`ifdef PRESET_CLAMP_EN
          hold_nx  = CLAMP_VALUE;
          state_nx = ST_LOAD;
`else
          state_nx = ST_WAIT_RELEASE;
`endif
        end
      end
      ST_LOAD: begin
        if (lcnt == LOAD_LAST) state_nx = ST_WAIT_RELEASE;
      end
      ST_WAIT_RELEASE: begin
        // Presses are only recognised from IDLE, so release bounce cannot retrigger a load.
        if (!level) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      hold  <= '0;
      lcnt  <= '0;
    end else begin
      state <= state_nx;
      hold  <= hold_nx;
      lcnt  <= ((state == ST_LOAD) && (state_nx == ST_LOAD)) ? lcnt + LW'(1) : '0;
    end
  end

  // Outputs decode registered state so an asynchronous reset drops them immediately.
  assign bus.set_bits   = (state == ST_LOAD) ? hold  : 6'd0;
  assign bus.clear_bits = (state == ST_LOAD) ? ~hold : 6'd0;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.invalid    = (state == ST_CAPTURE) && !preset_ok;
  assign bus.fsm_state  = state;

endmodule

// File: tb/tb_preset_loader.sv
// Self-checking bench for preset_loader with a timestamp-based reference model of press/load timing.
module tb_preset_loader;
  import preset_loader_pkg::*;

  localparam int D = 4;
  localparam int L = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  preset_loader_if bus ();

  preset_loader #(.DEBOUNCE_CYCLES(D), .LOAD_CYCLES(L)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: raw button history, debounced level, and event timestamps.
  bit         m_hist[$];
  bit         m_level;
  bit         m_idle;
  bit         m_wait;
  int         m_rise;
  int         m_cap;
  int         m_load_lo;
  int         m_load_hi;
  logic [5:0] m_hold;
  int         cyc = 0;

  int         dut_loads = 0;
  int         dut_inv = 0;
  logic       prev_active = 1'b0;
  logic [5:0] last_set = 6'd0;

  function automatic bit bcd_ok(input logic [5:0] p);
    int tens;
    int units;
    tens  = int'(p[5:4]);
    units = int'(p[3:0]);
    return (units <= 9) && (tens * 10 + units <= 30);
  endfunction

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hist = {};
    for (int i = 0; i < D + 2; i++) m_hist.push_back(1'b0);
    m_level   = 1'b0;
    m_idle    = 1'b1;
    m_wait    = 1'b0;
    m_rise    = -100;
    m_cap     = -100;
    m_load_lo = -100;
    m_load_hi = -100;
    m_hold    = 6'd0;
  endtask

  task automatic start_load(input int k, input logic [5:0] v);
    m_hold    = v;
    m_load_lo = k;
    m_load_hi = k + L - 1;
  endtask

  // Advance the model across the clock edge numbered cyc, given the button and preset sampled there.
  task automatic model_edge(input bit b, input logic [5:0] p);
    int k;
    bit lvl_before;
    bit old_idle;
    bit old_wait;
    bit flip;
    k          = cyc;
    lvl_before = m_level;
    old_idle   = m_idle;
    old_wait   = m_wait;
    if (old_wait && !lvl_before) begin
      m_wait = 1'b0;
      m_idle = 1'b1;
    end
    // Rise seen two edges ago: one edge to register the pulse, one for IDLE to react.
    if (old_idle && (m_rise == k - 2)) begin
      m_idle = 1'b0;
      m_cap  = k;
    end
    if (k == m_cap + 1) begin
      if (bcd_ok(p)) begin
        start_load(k, p);
      end else begin
`ifdef PRESET_CLAMP_EN
        start_load(k, 6'b11_0000);
`else
        m_wait = 1'b1;
`endif
      end
    end
    if (k == m_load_hi + 1) m_wait = 1'b1;
    m_hist.push_back(b);
    if (m_hist.size() > D + 2) void'(m_hist.pop_front());
    // The level flips once D consecutive synchronised samples (two edges old) all disagree with it.
    flip = 1'b1;
    for (int i = 2; i <= D + 1; i++) begin
      if (m_hist[m_hist.size() - 1 - i] == m_level) flip = 1'b0;
    end
    if (flip) begin
      m_level = !m_level;
      if (m_level) m_rise = k;
    end
  endtask

  task automatic tick(input bit b);
    int   k;
    bit   in_load;
    logic active;
    bus.button = b;
    @(posedge clock);
    model_edge(b, bus.preset);
    k = cyc;
    cyc++;
    #1;
    in_load = (k >= m_load_lo) && (k <= m_load_hi);
    chk("set_bits",   bus.set_bits,   in_load ? m_hold : 6'd0);
    chk("clear_bits", bus.clear_bits, in_load ? ~m_hold : 6'd0);
    chk("busy",       6'(bus.busy),    6'(!m_idle));
    chk("invalid",    6'(bus.invalid), 6'((k == m_cap) && !bcd_ok(bus.preset)));
    active = |(bus.set_bits | bus.clear_bits);
    if (active && !prev_active) begin
      dut_loads++;
      last_set = bus.set_bits;
    end
    prev_active = active;
    if (bus.invalid === 1'b1) dut_inv++;
  endtask

  task automatic hold_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      model_reset();
      cyc++;
    end
    prev_active = 1'b0;
  endtask

  task automatic press_and_release(input logic [5:0] p, input int hi, input int lo);
    bus.preset = p;
    for (int i = 0; i < hi; i++) tick(1'b1);
    for (int i = 0; i < lo; i++) tick(1'b0);
  endtask

  initial begin
    int l0;
    int i0;
    bit bounce_hi[10];
    bit bounce_lo[6];
    bounce_hi = '{1, 1, 0, 1, 0, 0, 1, 1, 1, 0};
    bounce_lo = '{0, 1, 0, 0, 1, 0};
    model_reset();

    // Reset held low with the button pressed: everything quiet, then exactly one load.
    bus.button = 1'b1;
    bus.preset = 6'b10_0101;
    reset      = 1'b0;
    hold_reset(3);
    #1;
    chk("rst_set",     bus.set_bits,        6'd0);
    chk("rst_clear",   bus.clear_bits,      6'd0);
    chk("rst_busy",    6'(bus.busy),        6'd0);
    chk("rst_invalid", 6'(bus.invalid),     6'd0);
    chk("rst_state",   6'(bus.fsm_state),   6'(ST_IDLE));
    reset = 1'b1;
    l0 = dut_loads;
    for (int i = 0; i < 14; i++) tick(1'b1);
    chk("held_loads", 6'(dut_loads - l0), 6'd1);
    chk("held_busy",  6'(bus.busy),       6'd1);
    for (int i = 0; i < D + 6; i++) tick(1'b0);

    // Clean press of 25: strobes at a fixed latency of 2+D+2, preset changes during LOAD ignored.
    bus.preset = 6'b10_0101;
    for (int i = 0; i <= 11; i++) begin
      tick(1'b1);
      if (i == 7 || i == 10) chk("lat_idle_set", bus.set_bits, 6'd0);
      if (i == 8 || i == 9) begin
        chk("lat_set",   bus.set_bits,   6'b10_0101);
        chk("lat_clear", bus.clear_bits, 6'b01_1010);
      end
      if (i == 8) bus.preset = 6'b00_0001;
    end
    for (int i = 0; i < D + 6; i++) tick(1'b0);

    // Bouncy press and bouncy release: one load only.
    bus.preset = 6'b01_0011;
    l0 = dut_loads;
    foreach (bounce_hi[i]) tick(bounce_hi[i]);
    for (int i = 0; i < 12; i++) tick(1'b1);
    foreach (bounce_lo[i]) tick(bounce_lo[i]);
    for (int i = 0; i < 12; i++) tick(1'b0);
    chk("bounce_loads", 6'(dut_loads - l0), 6'd1);

    // Out-of-range presets: 31 and units digit 10.
    l0 = dut_loads;
    i0 = dut_inv;
    press_and_release(6'b11_0001, 14, D + 6);
    chk("inv31_pulses", 6'(dut_inv - i0), 6'd1);
`ifdef PRESET_CLAMP_EN
    chk("inv31_loads", 6'(dut_loads - l0), 6'd1);
    chk("inv31_clamp", last_set,           6'b11_0000);
`else
    chk("inv31_loads", 6'(dut_loads - l0), 6'd0);
`endif
    l0 = dut_loads;
    i0 = dut_inv;
    press_and_release(6'b00_1010, 14, D + 6);
    chk("inv10_pulses", 6'(dut_inv - i0), 6'd1);
`ifdef PRESET_CLAMP_EN
    chk("inv10_loads", 6'(dut_loads - l0), 6'd1);
    chk("inv10_clamp", last_set,           6'b11_0000);
`else
    chk("inv10_loads", 6'(dut_loads - l0), 6'd0);
`endif

    // Reset mid-LOAD with the button still held: outputs drop at once, then one fresh load.
    bus.preset = 6'b01_0111;
    for (int i = 0; i < 20; i++) begin
      if (!((cyc - 1 >= m_load_lo) && (cyc - 1 <= m_load_hi))) tick(1'b1);
    end
    chk("pre_reset_set", bus.set_bits, 6'b01_0111);
    #3;
    reset = 1'b0;
    #1;
    chk("mid_rst_set",   bus.set_bits,      6'd0);
    chk("mid_rst_clear", bus.clear_bits,    6'd0);
    chk("mid_rst_busy",  6'(bus.busy),      6'd0);
    chk("mid_rst_state", 6'(bus.fsm_state), 6'(ST_IDLE));
    hold_reset(2);
    #1;
    reset = 1'b1;
    l0 = dut_loads;
    for (int i = 0; i < 14; i++) tick(1'b1);
    chk("post_rst_loads", 6'(dut_loads - l0), 6'd1);
    for (int i = 0; i < D + 6; i++) tick(1'b0);

    // Random button bursts and preset changes against the model.
    for (int s = 0; s < 60; s++) begin
      bit v;
      int len;
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      if ((cyc - 1 != m_cap) && ($urandom_range(0, 2) == 0)) bus.preset = 6'($urandom_range(0, 63));
      for (int i = 0; i < len; i++) tick(v);
    end
    for (int i = 0; i < D + 8; i++) tick(1'b0);
    chk("final_busy", 6'(bus.busy), 6'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
